// File: rtl/fetch_queue.sv
// Instruction prefetch buffer between fetch and IF/ID: an in-order FIFO of {pc, instr} pairs
// that absorbs decode stalls and drops every buffered wrong-path entry on a redirect.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int AW     = 2,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_push_valid,
  input  logic [DATA_W-1:0] i_push_instr,
  input  logic [DATA_W-1:0] i_push_pc,
  output logic              o_push_ready,
  input  logic              i_pop_ready,
  output logic              o_pop_valid,
  output logic [DATA_W-1:0] o_pop_instr,
  output logic [DATA_W-1:0] o_pop_pc,
  output logic [AW:0]       o_count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [DATA_W-1:0] pc_mem    [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;

  logic push;
  logic pop;

  // Handshakes decode from the registered count only, so a full queue refuses a push
  // even when the head is being popped in the same cycle.
  assign o_push_ready = (count_reg != FULL_COUNT);
  assign o_pop_valid  = (count_reg != '0);
  assign push         = i_push_valid & o_push_ready;
  assign pop          = i_pop_ready & o_pop_valid;

  assign o_pop_instr = o_pop_valid ? instr_mem[rd_ptr_reg] : '0;
  assign o_pop_pc    = o_pop_valid ? pc_mem[rd_ptr_reg]    : '0;
  assign o_count     = count_reg;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (i_flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  // Flush only rewinds the pointers; stale entries stay in storage but are unreachable.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          instr_mem[gi] <= '0;
          pc_mem[gi]    <= '0;
        end else if (!i_flush && push && (wr_ptr_reg == AW'(gi))) begin
          instr_mem[gi] <= i_push_instr;
          pc_mem[gi]    <= i_push_pc;
        end
      end
    end
  endgenerate

endmodule
